// File: rtl/mac_pkg.sv
// Shared types and widths for the MAC sequencing controller.
package mac_pkg;

  localparam int unsigned OP_W      = 32;
  localparam int unsigned ACC_W     = 64;
  localparam int unsigned LEN_W_DEF = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } mac_state_t;

endpackage

// File: rtl/mac_vld_pipe.sv
// LAT-deep valid shift register tracking products in flight through the datapath.
module mac_vld_pipe #(
  parameter int unsigned LAT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic vld_in,
  output logic tap,
  // High when a valid is pending behind the tap (including the one entering now)
  output logic occ_nz
);

  localparam logic [LAT-1:0] TapMask = LAT'(1) << (LAT - 1);

  logic [LAT-1:0] pipe_q, pipe_d;

  // Shift one stage per cycle; new valids enter at bit 0, the tap is the top bit.
  always_comb begin
    pipe_d = (pipe_q << 1) | LAT'(vld_in);
  end

  // Pipeline register; reset drops every in-flight valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  // Outputs: tap bit and pending occupancy behind it.
  always_comb begin
    tap    = pipe_q[LAT-1];
    occ_nz = (|(pipe_q & ~TapMask)) | vld_in;
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: issues operand pairs to a fixed-latency multiplier and
// accumulates the returned products with sticky signed-overflow detection.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int unsigned LAT   = 3,
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_acc,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [OP_W-1:0]  op_a,
  input  logic [OP_W-1:0]  op_b,
  output logic             dp_vld,
  output logic [OP_W-1:0]  dp_a,
  output logic [OP_W-1:0]  dp_b,
  input  logic [ACC_W-1:0] dp_prod,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             res_ovf,
  output logic             busy
);

  mac_state_t       state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             dp_vld_q, dp_vld_d;
  logic [OP_W-1:0]  dp_a_q, dp_a_d;
  logic [OP_W-1:0]  dp_b_q, dp_b_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] sum;
  logic             cmd_hs, op_hs;
  logic             tap, occ_nz;

  mac_vld_pipe #(
    .LAT (LAT)
  ) u_vld_pipe (
    .clk    (clk),
    .rst    (rst),
    .vld_in (dp_vld_q),
    .tap    (tap),
    .occ_nz (occ_nz)
  );

  // Handshake-facing outputs decoded from registered state; cmd_ready held low in reset.
  always_comb begin
    cmd_ready = (state_q == StIdle) && !rst;
    op_ready  = (state_q == StRun) && (rem_q != '0);
    res_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    dp_vld    = dp_vld_q;
    dp_a      = dp_a_q;
    dp_b      = dp_b_q;
    res_data  = acc_q;
    res_ovf   = ovf_q;
    cmd_hs    = cmd_valid && cmd_ready;
    op_hs     = op_valid && op_ready;
  end

  // Next-state: FSM, issue registers, and accumulate on the delay-line tap.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    dp_vld_d = 1'b0;
    dp_a_d   = dp_a_q;
    dp_b_d   = dp_b_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    sum      = acc_q + dp_prod;

    if (tap) begin
      acc_d = sum;
      if ((acc_q[ACC_W-1] == dp_prod[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1])) begin
        ovf_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (cmd_hs) begin
          rem_d = cmd_len;
          if (!cmd_acc) begin
            acc_d = '0;
            ovf_d = 1'b0;
          end
          state_d = (cmd_len != '0) ? StRun : StDone;
        end
      end
      StRun: begin
        if (op_hs) begin
          dp_vld_d = 1'b1;
          dp_a_d   = op_a;
          dp_b_d   = op_b;
          rem_d    = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Final product is at the tap with nothing behind it: finish on this accumulate.
        if (tap && !occ_nz) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      rem_q    <= '0;
      dp_vld_q <= 1'b0;
      dp_a_q   <= '0;
      dp_b_q   <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      dp_vld_q <= dp_vld_d;
      dp_a_q   <= dp_a_d;
      dp_b_q   <= dp_b_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a behavioural LAT-cycle multiplier.
module tb_mac_seq_ctrl;

  localparam int unsigned LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_acc;
  logic [7:0]  cmd_len;
  logic        op_valid, op_ready;
  logic [31:0] op_a, op_b;
  logic        dp_vld;
  logic [31:0] dp_a, dp_b;
  logic [63:0] dp_prod;
  logic        res_valid, res_ready, res_ovf, busy;
  logic [63:0] res_data;

  logic        garbage_en;
  logic [63:0] dpm [LAT];

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  mac_seq_ctrl #(
    .LAT   (LAT),
    .LEN_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .cmd_acc   (cmd_acc),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .dp_vld    (dp_vld),
    .dp_a      (dp_a),
    .dp_b      (dp_b),
    .dp_prod   (dp_prod),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_ovf   (res_ovf),
    .busy      (busy)
  );

  // Stand-in multiplier: product of the dp_vld cycle appears LAT cycles later.
  always @(posedge clk) begin
    dpm[0] <= $signed({{32{dp_a[31]}}, dp_a}) * $signed({{32{dp_b[31]}}, dp_b});
    for (int i = 1; i < LAT; i++) dpm[i] <= dpm[i-1];
  end
  assign dp_prod = garbage_en ? 64'h0123_4567_89AB_CDEF : dpm[LAT-1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [7:0] len, input logic acc);
    int n = 0;
    cmd_valid = 1'b1; cmd_len = len; cmd_acc = acc;
    while (!cmd_ready && n < 50) begin step(); n++; end
    if (n == 50) chk("cmd_ready_timeout", 64'(n), 64'd0);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic send_op(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    op_valid = 1'b1; op_a = a; op_b = b;
    while (!op_ready && n < 50) begin step(); n++; end
    if (n == 50) chk("op_ready_timeout", 64'(n), 64'd0);
    step();
    op_valid = 1'b0;
  endtask

  // Count cycles until res_valid; compare to the expected latency.
  task automatic wait_res(input string tag, input int exp_steps);
    int n = 0;
    while (!res_valid && n < 50) begin step(); n++; end
    chk(tag, 64'(n), 64'(exp_steps));
  endtask

  task automatic take_res();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("idle_after_res", {62'd0, cmd_ready, res_valid}, 64'b10);
  endtask

  initial begin
    rst = 1'b1; garbage_en = 1'b0;
    cmd_valid = 1'b0; cmd_len = '0; cmd_acc = 1'b0;
    op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
    step(); step();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_outs", {57'd0, op_ready, dp_vld, res_valid, res_ovf, busy, |dp_a, |dp_b}, 64'd0);
    chk("rst_res_data", res_data, 64'd0);
    @(negedge clk) rst = 1'b0;
    step();
    chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);

    // N=1, (3,-5)
    do_cmd(8'd1, 1'b0);
    chk("run_op_ready", {62'd0, op_ready, busy}, 64'b11);
    send_op(32'd3, 32'hFFFF_FFFB);
    chk("issue_vld", 64'(dp_vld), 64'd1);
    chk("issue_a", 64'(dp_a), 64'd3);
    chk("issue_b", 64'(dp_b), 64'hFFFF_FFFB);
    chk("op_ready_after_last", 64'(op_ready), 64'd0);
    step();
    chk("vld_one_cycle", 64'(dp_vld), 64'd0);
    wait_res("lat_n1", 3);
    chk("res_n1", res_data, 64'hFFFF_FFFF_FFFF_FFF1);
    chk("ovf_n1", 64'(res_ovf), 64'd0);
    take_res();

    // N=4 back-to-back
    do_cmd(8'd4, 1'b0);
    send_op(32'd1, 32'd2);
    send_op(32'd3, 32'd4);
    send_op(32'd5, 32'd6);
    send_op(32'd7, 32'd8);
    chk("op_ready_drop_n4", 64'(op_ready), 64'd0);
    wait_res("lat_n4", 4);
    chk("res_n4", res_data, 64'd100);
    take_res();

    // Accumulate onto previous result
    do_cmd(8'd1, 1'b1);
    send_op(32'd10, 32'd10);
    wait_res("lat_acc", 4);
    chk("res_acc", res_data, 64'd200);
    take_res();

    // N=0 clears and completes immediately
    do_cmd(8'd0, 1'b0);
    wait_res("lat_n0", 0);
    chk("res_n0", res_data, 64'd0);
    take_res();

    // Overflow: 2^62 + 2^62
    do_cmd(8'd2, 1'b0);
    send_op(32'h8000_0000, 32'h8000_0000);
    send_op(32'h8000_0000, 32'h8000_0000);
    wait_res("lat_ovf", 4);
    chk("res_ovf_data", res_data, 64'h8000_0000_0000_0000);
    chk("res_ovf_flag", 64'(res_ovf), 64'd1);
    take_res();
    do_cmd(8'd1, 1'b1);
    send_op(32'd0, 32'd0);
    wait_res("lat_sticky", 4);
    chk("sticky_data", res_data, 64'h8000_0000_0000_0000);
    chk("sticky_ovf", 64'(res_ovf), 64'd1);
    take_res();

    // N=3 with bubbles: 6 - 20 + 42 = 28, then a 10-cycle stall
    do_cmd(8'd3, 1'b0);
    repeat ($urandom_range(1, 3)) step();
    send_op(32'd2, 32'd3);
    repeat ($urandom_range(1, 3)) step();
    send_op(32'hFFFF_FFFC, 32'd5);
    repeat ($urandom_range(0, 3)) step();
    send_op(32'd6, 32'd7);
    wait_res("lat_bubble", 4);
    cmd_valid = 1'b1; cmd_len = 8'd1; cmd_acc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", 64'(res_valid), 64'd1);
      chk("stall_data", res_data, 64'd28);
      chk("stall_cmd_ready", 64'(cmd_ready), 64'd0);
      step();
    end
    cmd_valid = 1'b0;
    take_res();

    // Reset mid-operation with garbage on dp_prod
    do_cmd(8'd4, 1'b0);
    send_op(32'd1, 32'd1);
    send_op(32'd1, 32'd1);
    garbage_en = 1'b1;
    rst = 1'b1;
    #1;
    chk("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("midrst_outs", {57'd0, op_ready, dp_vld, res_valid, res_ovf, busy, |dp_a, |dp_b}, 64'd0);
    chk("midrst_data", res_data, 64'd0);
    step(); step();
    @(negedge clk) rst = 1'b0;
    step(); step(); step(); step();
    garbage_en = 1'b0;
    chk("postrst_idle", {62'd0, cmd_ready, busy}, 64'b10);
    chk("postrst_data", res_data, 64'd0);
    do_cmd(8'd1, 1'b0);
    send_op(32'd2, 32'd3);
    wait_res("lat_postrst", 4);
    chk("res_postrst", res_data, 64'd6);
    chk("ovf_postrst", 64'(res_ovf), 64'd0);
    take_res();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
